// File: rtl/cpu_pkg.sv
// Shared types for the MIPS fetch/sequencing path:
// sequencer state encoding, next-PC select codes and reset vector.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH      = 3'd1,
        DISPATCH   = 3'd2,
        WAIT_EXEC  = 3'd3,
        HALT       = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Register jump outranks jump, which outranks a taken branch.
    function automatic pc_sel_e pick_sel(
        input logic is_branch,
        input logic br_taken,
        input logic is_jump,
        input logic is_jr
    );
        pc_sel_e sel;
        sel = SEL_SEQ;
        if (is_jr)
            sel = SEL_JR;
        else if (is_jump)
            sel = SEL_J;
        else if (is_branch && br_taken)
            sel = SEL_BR;
        return sel;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection and target arithmetic,
// plus word-alignment check on register-jump targets.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        is_branch,
    input  logic        br_taken,
    input  logic        is_jump,
    input  logic        is_jr,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_target
);

    pc_sel_e     sel;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign unused_opcode = ^instr[31:26];

    always_comb begin
        sel               = pick_sel(is_branch, br_taken, is_jump, is_jr);
        pc_plus4          = pc + 32'd4;
        br_off            = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc           = pc_plus4;
        misaligned_target = 1'b0;
        unique case (sel)
            SEL_SEQ: next_pc = pc_plus4;
            SEL_BR:  next_pc = pc_plus4 + br_off;
            SEL_J:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            SEL_JR: begin
                next_pc           = rs_data;
                misaligned_target = |rs_data[1:0];
            end
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch over req/ack, dispatch,
// wait for execute, then commit the next PC.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        br_taken,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count,
    output logic        misalign
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        misalign_q, misalign_d;
    logic [31:0] next_pc;
    logic        bad_target;

    next_pc_calc u_next_pc (
        .pc                (pc_q),
        .instr             (instr_q),
        .rs_data           (rs_data),
        .is_branch         (is_branch),
        .br_taken          (br_taken),
        .is_jump           (is_jump),
        .is_jr             (is_jr),
        .next_pc           (next_pc),
        .pc_plus4          (pc_plus4),
        .misaligned_target (bad_target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        unique case (state_q)
            FETCH_IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DISPATCH;
                end
            end
            DISPATCH: state_d = WAIT_EXEC;
            WAIT_EXEC: begin
                if (exec_done && !stall) begin
                    if (ALIGN_CHECK && bad_target) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = next_pc;
                        count_d = count_q + 32'd1;
                        state_d = FETCH_IDLE;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == DISPATCH);
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scenario tasks with
// a queue of expected committed PCs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic        br_taken = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_jr = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;
    logic        misalign;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .stall       (stall),
        .is_branch   (is_branch),
        .br_taken    (br_taken),
        .is_jump     (is_jump),
        .is_jr       (is_jr),
        .rs_data     (rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_count (instr_count),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] exp_q[$];
    logic [31:0] a, exp_pc;
    bit          ok, st, v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, holds ack low for lat cycles,
    // then returns rdata; leaves the DUT in DISPATCH.
    task automatic do_fetch(input logic [31:0] rdata, input int lat,
                            output logic [31:0] addr, output bit fok,
                            output bit stable);
        fok    = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (imem_req === 1'b1) begin
                fok = 1'b1;
                break;
            end
            tick();
        end
        addr = imem_addr;
        if (!fok) return;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== addr) stable = 1'b0;
        end
        imem_rdata = rdata;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    // From DISPATCH: step into WAIT_EXEC, then resolve with flags.
    task automatic do_exec(input logic br, input logic tk,
                           input logic j, input logic jr,
                           input logic [31:0] rs, output bit vld);
        tick();
        vld       = instr_valid;
        is_branch = br;
        br_taken  = tk;
        is_jump   = j;
        is_jr     = jr;
        rs_data   = rs;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        is_branch = 1'b0;
        br_taken  = 1'b0;
        is_jump   = 1'b0;
        is_jr     = 1'b0;
        rs_data   = 32'd0;
    endtask

    task automatic test_reset();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 32'd0) begin
            n_err++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0);
        end
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req got=%b exp=0", imem_req);
        end
        n_cmp++;
        if (instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count got=%h exp=0", instr_count);
        end
        n_cmp++;
        if (instr !== 32'd0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL reset_misc got=%h/%b/%b exp=0/0/0",
                     instr, instr_valid, misalign);
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL bubble_req got=%b exp=0", imem_req);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL first_req got=%b/%h exp=1/00000000",
                     imem_req, imem_addr);
        end
        m_cnt = 32'd0;
    endtask

    task automatic test_sequential();
        int lats[2] = '{0, 3};
        logic [31:0] words[2] = '{32'h0000_0020, 32'h0109_5020};
        for (int k = 0; k < 2; k++) begin
            do_fetch(words[k], lats[k], a, ok, st);
            n_cmp++;
            if (ok !== 1'b1 || st !== 1'b1) begin
                n_err++;
                $display("FAIL seq_req%0d got ok=%b stable=%b exp=1/1", k, ok, st);
            end
            n_cmp++;
            if (a !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL seq_addr%0d got=%h exp=%h", k, a, 32'(4 * k));
            end
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== words[k]) begin
                n_err++;
                $display("FAIL seq_dispatch%0d got=%b/%h exp=1/%h",
                         k, instr_valid, instr, words[k]);
            end
            exp_q.push_back(32'(4 * k + 4));
            do_exec(0, 0, 0, 0, 32'd0, v);
            n_cmp++;
            if (v !== 1'b0) begin
                n_err++;
                $display("FAIL seq_pulse%0d got=%b exp=0", k, v);
            end
            m_cnt++;
            exp_pc = exp_q.pop_front();
            n_cmp++;
            if (pc !== exp_pc || instr_count !== m_cnt) begin
                n_err++;
                $display("FAIL seq_commit%0d got=%h/%0d exp=%h/%0d",
                         k, pc, instr_count, exp_pc, m_cnt);
            end
            n_cmp++;
            if (imem_req !== 1'b0 || pc_plus4 !== exp_pc + 32'd4) begin
                n_err++;
                $display("FAIL seq_bubble%0d got=%b/%h exp=0/%h",
                         k, imem_req, pc_plus4, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        logic        tk_tab[3]  = '{1'b1, 1'b0, 1'b0};
        logic [31:0] exp_tab[3] = '{32'h0000_00FC, 32'h0000_0100, 32'h0000_0104};
        logic [31:0] prev;
        bit          held;
        do_fetch(32'h0800_0040, 1, a, ok, st);
        exp_q.push_back(32'h0000_0100);
        do_exec(0, 0, 1, 0, 32'd0, v);
        m_cnt++;
        exp_pc = exp_q.pop_front();
        n_cmp++;
        if (pc !== exp_pc) begin
            n_err++;
            $display("FAIL br_setup got=%h exp=%h", pc, exp_pc);
        end
        prev = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'h1000_FFFE, k, a, ok, st);
            exp_q.push_back(exp_tab[k]);
            do_exec(1, tk_tab[k], 0, 0, 32'd0, v);
            m_cnt++;
            exp_pc = exp_q.pop_front();
            n_cmp++;
            if (a !== prev || pc !== exp_pc || instr_count !== m_cnt) begin
                n_err++;
                $display("FAIL br%0d got addr=%h pc=%h cnt=%0d exp=%h/%h/%0d",
                         k, a, pc, instr_count, prev, exp_pc, m_cnt);
            end
            prev = exp_tab[k];
        end
        do_fetch(32'h1000_FFFE, 0, a, ok, st);
        tick();
        is_branch = 1'b1;
        br_taken  = 1'b1;
        stall     = 1'b1;
        exec_done = 1'b1;
        held      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pc !== 32'h0000_0104 || instr_count !== m_cnt || imem_req !== 1'b0)
                held = 1'b0;
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_err++;
            $display("FAIL br_stall_hold got pc=%h cnt=%0d exp=00000104/%0d",
                     pc, instr_count, m_cnt);
        end
        exp_q.push_back(32'h0000_0100);
        stall = 1'b0;
        tick();
        exec_done = 1'b0;
        is_branch = 1'b0;
        br_taken  = 1'b0;
        m_cnt++;
        exp_pc = exp_q.pop_front();
        n_cmp++;
        if (pc !== exp_pc || instr_count !== m_cnt) begin
            n_err++;
            $display("FAIL br_stall_commit got=%h/%0d exp=%h/%0d",
                     pc, instr_count, exp_pc, m_cnt);
        end
    endtask

    task automatic test_jump();
        logic        j_tab[3]  = '{1'b0, 1'b1, 1'b1};
        logic        jr_tab[3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] rs_tab[3] = '{32'h1000_0000, 32'h0000_0000, 32'h2000_0004};
        logic [31:0] ex_tab[3] = '{32'h1000_0000, 32'h1000_0100, 32'h2000_0004};
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'h0800_0040, 0, a, ok, st);
            exp_q.push_back(ex_tab[k]);
            do_exec(jr_tab[k], jr_tab[k], j_tab[k], jr_tab[k], rs_tab[k], v);
            m_cnt++;
            exp_pc = exp_q.pop_front();
            n_cmp++;
            if (pc !== exp_pc || instr_count !== m_cnt) begin
                n_err++;
                $display("FAIL jump%0d got=%h/%0d exp=%h/%0d",
                         k, pc, instr_count, exp_pc, m_cnt);
            end
        end
    endtask

    task automatic test_misalign();
        bit quiet;
        do_fetch(32'h0060_0008, 0, a, ok, st);
        do_exec(0, 0, 0, 1, 32'h0000_0003, v);
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_err++;
            $display("FAIL mis_flag got=%b exp=1", misalign);
        end
        n_cmp++;
        if (pc !== 32'h2000_0004 || instr_count !== m_cnt) begin
            n_err++;
            $display("FAIL mis_hold got=%h/%0d exp=20000004/%0d",
                     pc, instr_count, m_cnt);
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = i[0];
            exec_done = 1'b1;
            tick();
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1
                || pc !== 32'h2000_0004)
                quiet = 1'b0;
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL halt_quiet got req=%b mis=%b pc=%h exp=0/1/20000004",
                     imem_req, misalign, pc);
        end
    endtask

    task automatic test_rst_during_fetch();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (misalign !== 1'b0 || pc !== 32'd0 || instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL halt_clear got=%b/%h/%0d exp=0/0/0",
                     misalign, pc, instr_count);
        end
        tick();
        rst = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fetch_req got=%b exp=0", imem_req);
        end
        tick();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        n_cmp++;
        if (instr !== 32'd0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL late_ack got=%h/%b exp=00000000/0", instr, instr_valid);
        end
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL refetch got=%b/%h exp=1/00000000", imem_req, imem_addr);
        end
        m_cnt = 32'd0;
        do_fetch(32'h0000_0020, 2, a, ok, st);
        exp_q.push_back(32'h0000_0004);
        do_exec(0, 0, 0, 0, 32'd0, v);
        m_cnt++;
        exp_pc = exp_q.pop_front();
        n_cmp++;
        if (a !== 32'd0 || pc !== exp_pc || instr_count !== m_cnt) begin
            n_err++;
            $display("FAIL after_rst got addr=%h pc=%h cnt=%0d exp=0/%h/%0d",
                     a, pc, instr_count, exp_pc, m_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_misalign();
        test_rst_during_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle program-counter controller for the MIPS CPU.
- Owns the PC register and fetches each instruction from instruction memory over a req/ack handshake.
- Hands the instruction to decode/execute and waits for execution to resolve control flow.
- Then computes and commits the next PC: sequential, branch, jump or register jump.
- Sits between the instruction memory port and the control/datapath unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1 a misaligned register-jump target halts the sequencer.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address, equals pc
- imem_ack  input  1  memory returns data this cycle
- imem_rdata  input  32  instruction word, valid with imem_ack
- instr  output  32  latched instruction
- instr_valid  output  1  one-cycle pulse, instr ready for decode
- exec_done  input  1  datapath has resolved the current instruction
- stall  input  1  holds the sequencer in WAIT_EXEC
- is_branch  input  1  current instruction is a conditional branch
- br_taken  input  1  branch condition true
- is_jump  input  1  J/JAL
- is_jr  input  1  JR/JALR
- rs_data  input  32  register-jump target
- pc  output  32  current PC
- pc_plus4  output  32  pc+4 (link value)
- instr_count  output  32  retired-instruction counter
- misalign  output  1  sticky misaligned-target flag

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - pc=RESET_PC, state=FETCH_IDLE, instr=0, instr_count=0.
  - imem_req=0, instr_valid=0, misalign=0.
- FSM states: FETCH_IDLE, FETCH, DISPATCH, WAIT_EXEC, HALT.
- FETCH_IDLE: imem_req=0. Always goes to FETCH next cycle, so there is one bubble after reset and after each commit.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, go to DISPATCH. Ack latency is unbounded.
  - imem_ack in any other state is ignored.
- DISPATCH: instr_valid=1 for exactly this cycle, then go to WAIT_EXEC.
- WAIT_EXEC:
  - If stall=1, exec_done is ignored and the state holds.
  - If exec_done=1 and stall=0: commit next PC, instr_count+1 (wraps at 2^32), go to FETCH_IDLE.
- Next-PC priority: is_jr > is_jump > (is_branch & br_taken) > pc_plus4.
  - Lower-priority flags are ignored when a higher one is set.
  - is_branch with br_taken=0 yields pc_plus4.
- Target arithmetic (all modulo 2^32, wrap silently):
  - Branch: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - Jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Register jump: rs_data.
- Misalignment (ALIGN_CHECK=1, is_jr selected, rs_data[1:0]!=0):
  - pc is not updated and instr_count does not increment.
  - misalign<=1 (sticky), go to HALT.
  - HALT holds imem_req=0 until rst.
  - With ALIGN_CHECK=0, rs_data is committed as-is.
- Timing:
  - pc_plus4 = pc+4, combinational.
  - All other outputs are registered or state-decoded.
  - Minimum instruction period is 4 cycles: FETCH_IDLE, FETCH with 0-wait ack, DISPATCH, WAIT_EXEC with immediate exec_done.

Decomposition:
- Shared package cpu_pkg holds:
  - State encoding constants.
  - Next-PC select encodings (SEL_SEQ, SEL_BR, SEL_J, SEL_JR).
  - Default RESET_PC.
- Sub-module next_pc_calc: purely combinational.
  - Inputs: pc, instr, rs_data, select flags.
  - Outputs: next_pc, misaligned_target.
  - pc_sequencer keeps the FSM, registers and counter.

Test Plan:
- Reset: rst=1 asserted mid-cycle -> outputs reset immediately: pc=0, imem_req=0, instr_count=0. After release -> imem_req=1, imem_addr=0 on the second edge.
- Sequential fetch, ack latency 0 and then 3 -> instr_valid pulses exactly once per instruction, one cycle after ack. pc goes 0->4->8 and instr_count goes 0->1->2.
- Branch at pc=0x100 with instr[15:0]=0xFFFE:
  - Taken -> pc=0xFC.
  - Not taken -> pc=0x104.
  - stall=1 with exec_done=1 for 5 cycles -> no commit until stall drops.
- Jump at pc=0x1000_0000 with instr[25:0]=0x40 -> pc=0x1000_0100. is_jr=1 and is_jump=1 together with rs_data=0x2000_0004 -> pc=0x2000_0004.
- JR with rs_data=0x0000_0003 -> misalign=1, state HALT, pc unchanged, imem_req stays 0 for 20 cycles, cleared only by rst.
- rst during outstanding FETCH, then late imem_ack -> the ack is ignored, fetch restarts from RESET_PC, instr stays 0.
